// File: rtl/lcd_msg_ctrl.sv
// lcd_msg_ctrl: HD44780-class LCD controller that initialises the panel, then writes a full page from a message ROM.
// Optional build macro LCD_AUTO_REFRESH_EN adds a periodic page rewrite while idle.
module lcd_msg_ctrl #(
    parameter int NUM_MSG      = 4,
    parameter int MSG_W        = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int EN_CYC       = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int REFRESH_CYC  = 50000000
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic [MSG_W-1:0]             msg_sel,
    input  logic                         refresh_req,
    output logic [MSG_W-1:0]             chr_msg,
    output logic [$clog2(ROWS*COLS)-1:0] chr_addr,
    input  logic [7:0]                   chr_data,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   LCD_DATA,
    output logic                         LCD_RW,
    output logic                         LCD_EN,
    output logic                         LCD_RS
);
    localparam int            AW        = $clog2(ROWS*COLS);
    localparam int            CW        = $clog2(COLS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS*COLS-1);
    localparam logic [7:0]    FUNC_SET  = (ROWS == 2) ? 8'h38 : 8'h30;

    typedef enum logic [2:0] {ST_PWRUP, ST_IDLE, ST_FETCH, ST_LOAD, ST_SETUP, ST_ENH, ST_HOLD} state_t;
    typedef enum logic [1:0] {CTX_INIT, CTX_ADDR, CTX_CHAR} ctx_t;

    state_t           r_state, w_state_next;
    ctx_t             r_ctx, w_ctx_next;
    logic [31:0]      r_cnt, w_cnt_next;
    logic [1:0]       r_idx, w_idx_next;
    logic [AW-1:0]    r_addr, w_addr_next;
    logic [MSG_W-1:0] r_msg, w_msg_next;
    logic [7:0]       r_data, w_data_next;
    logic             r_rs, w_rs_next;
    logic             r_en;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             r_pend, w_pend_next;

    logic             w_sel_valid, w_event, w_ref_hit, w_load_cmd, w_start_page, w_next_row;
    logic [7:0]       w_cmd_byte;
    logic [31:0]      w_wait_last;
    logic [AW-1:0]    w_addr_inc;

    assign w_sel_valid = {{(32-MSG_W){1'b0}}, msg_sel} < 32'(NUM_MSG);
    assign w_event     = (w_sel_valid && (msg_sel != r_msg)) || refresh_req;

`ifdef LCD_AUTO_REFRESH_EN
    logic [31:0] r_ref_cnt;

    // Counts idle cycles only, so every completed write restarts the period.
    always_ff @(posedge iCLK) begin
        if (!iRST_N || (r_state != ST_IDLE) || w_ref_hit)
            r_ref_cnt <= '0;
        else
            r_ref_cnt <= r_ref_cnt + 32'd1;
    end
    assign w_ref_hit = (r_state == ST_IDLE) && (r_ref_cnt == 32'(REFRESH_CYC - 1));
`else
    logic w_unused_refresh;
    assign w_unused_refresh = &{1'b0, REFRESH_CYC[0]};
    assign w_ref_hit        = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_ctx_next   = r_ctx;
        w_cnt_next   = r_cnt + 32'd1;
        w_idx_next   = r_idx;
        w_addr_next  = r_addr;
        w_msg_next   = r_msg;
        w_data_next  = r_data;
        w_rs_next    = r_rs;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_pend_next  = r_pend || (w_event && r_busy && (r_ctx != CTX_INIT));
        w_load_cmd   = 1'b0;
        w_start_page = 1'b0;
        w_cmd_byte   = 8'h80;
        w_addr_inc   = r_addr + 1'b1;
        w_next_row   = (ROWS == 2) ? w_addr_inc[AW-1] : 1'b0;
        // Only the Clear Display command needs the long settle time.
        w_wait_last  = ((r_ctx == CTX_INIT) && (r_idx == 2'd2)) ? 32'(CLR_WAIT_CYC - 1)
                                                                 : 32'(CMD_WAIT_CYC - 1);
        unique case (r_state)
            ST_PWRUP: begin
                if (r_cnt == 32'(PWRUP_CYC - 1)) begin
                    w_load_cmd = 1'b1;
                    w_cmd_byte = FUNC_SET;
                    w_ctx_next = CTX_INIT;
                    w_idx_next = 2'd0;
                end
            end
            ST_IDLE: begin
                w_cnt_next = '0;
                if (w_event || w_ref_hit)
                    w_start_page = 1'b1;
            end
            ST_FETCH: begin
                w_state_next = ST_LOAD;
                w_cnt_next   = '0;
            end
            ST_LOAD: begin
                w_state_next = ST_SETUP;
                w_cnt_next   = '0;
                w_data_next  = chr_data;
                w_rs_next    = 1'b1;
                w_ctx_next   = CTX_CHAR;
            end
            ST_SETUP: begin
                if (r_cnt == 32'(SETUP_CYC - 1)) begin
                    w_state_next = ST_ENH;
                    w_cnt_next   = '0;
                end
            end
            ST_ENH: begin
                if (r_cnt == 32'(EN_CYC - 1)) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = '0;
                end
            end
            ST_HOLD: begin
                if (r_cnt == w_wait_last) begin
                    unique case (r_ctx)
                        CTX_INIT: begin
                            if (r_idx == 2'd3) begin
                                w_start_page = 1'b1;
                            end else begin
                                w_idx_next = r_idx + 2'd1;
                                w_load_cmd = 1'b1;
                                unique case (r_idx)
                                    2'd0:    w_cmd_byte = 8'h0C;
                                    2'd1:    w_cmd_byte = 8'h01;
                                    default: w_cmd_byte = 8'h06;
                                endcase
                            end
                        end
                        CTX_ADDR: begin
                            w_state_next = ST_FETCH;
                            w_cnt_next   = '0;
                        end
                        default: begin
                            if (r_addr == LAST_ADDR) begin
                                w_addr_next = '0;
                                w_done_next = 1'b1;
                                // An event landing on the final cycle counts as pending too.
                                if (r_pend || w_event) begin
                                    w_start_page = 1'b1;
                                end else begin
                                    w_state_next = ST_IDLE;
                                    w_busy_next  = 1'b0;
                                    w_cnt_next   = '0;
                                end
                            end else begin
                                w_addr_next = w_addr_inc;
                                if (w_addr_inc[CW-1:0] == '0) begin
                                    w_load_cmd = 1'b1;
                                    w_cmd_byte = w_next_row ? 8'hC0 : 8'h80;
                                    w_ctx_next = CTX_ADDR;
                                end else begin
                                    w_state_next = ST_FETCH;
                                    w_cnt_next   = '0;
                                end
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state_next = ST_PWRUP;
                w_cnt_next   = '0;
            end
        endcase

        if (w_start_page) begin
            if (w_sel_valid)
                w_msg_next = msg_sel;
            w_addr_next = '0;
            w_pend_next = 1'b0;
            w_busy_next = 1'b1;
            w_load_cmd  = 1'b1;
            w_cmd_byte  = 8'h80;
            w_ctx_next  = CTX_ADDR;
        end

        if (w_load_cmd) begin
            w_state_next = ST_SETUP;
            w_cnt_next   = '0;
            w_data_next  = w_cmd_byte;
            w_rs_next    = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state <= ST_PWRUP;
            r_ctx   <= CTX_INIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_msg   <= '0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ctx   <= w_ctx_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_addr  <= w_addr_next;
            r_msg   <= w_msg_next;
            r_data  <= w_data_next;
            r_rs    <= w_rs_next;
            r_en    <= (w_state_next == ST_ENH);
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_pend  <= w_pend_next;
        end
    end

    assign chr_msg  = r_msg;
    assign chr_addr = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign LCD_DATA = r_data;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = r_en;
    assign LCD_RS   = r_rs;
endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// tb_lcd_msg_ctrl: directed bench for lcd_msg_ctrl with a registered message-ROM model and an LCD bus monitor.
// Compile both files with LCD_AUTO_REFRESH_EN defined to check the auto-refresh build instead of the quiet-idle case.
`timescale 1ns/1ps
module tb_lcd_msg_ctrl;
    localparam int COLS       = 16;
    localparam int ROWS       = 2;
    localparam int PAGE_BYTES = ROWS * (COLS + 1);
    localparam int PAGE_CYC   = ROWS * (1 + 2 + 4) + ROWS * COLS * (2 + 1 + 2 + 4);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] msg_sel = 2'd0;
    logic       refresh_req = 1'b0;
    logic [1:0] chr_msg;
    logic [4:0] chr_addr;
    logic [7:0] chr_data = 8'h00;
    logic       busy, done;
    logic [7:0] lcd_data;
    logic       lcd_rw, lcd_en, lcd_rs;

    lcd_msg_ctrl #(
        .NUM_MSG(4), .COLS(COLS), .ROWS(ROWS), .PWRUP_CYC(10), .SETUP_CYC(1), .EN_CYC(2),
        .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(8), .REFRESH_CYC(500)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .msg_sel(msg_sel), .refresh_req(refresh_req),
        .chr_msg(chr_msg), .chr_addr(chr_addr), .chr_data(chr_data), .busy(busy), .done(done),
        .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_EN(lcd_en), .LCD_RS(lcd_rs)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input int m, input int a);
        return 8'((8'h30 + m * 40 + a * 3) & 255);
    endfunction

    always @(posedge clk) chr_data <= rom_byte(int'(chr_msg), int'(chr_addr));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s: 0x%0h ok", name, act);
        end
    endtask

    // Bus monitor: captures every byte on EN rise and flags timing violations.
    typedef struct {logic [7:0] d; logic rs; logic [1:0] m; int cyc;} cap_t;
    cap_t caps[$];
    int   done_cyc[$];
    logic done_busy[$];
    logic [7:0] p_data = 8'h00;
    logic p_rs = 1'b0, p_en = 1'b0, p_chg = 1'b0;
    int   en_len = 0, en_bad = 0, stab_bad = 0;
    wire  w_chg  = (lcd_data !== p_data) || (lcd_rs !== p_rs);
    wire  w_rise = lcd_en && !p_en;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_data <= lcd_data;
            p_rs   <= lcd_rs;
            p_en   <= 1'b0;
            p_chg  <= 1'b0;
            en_len <= 0;
        end else begin
            p_data <= lcd_data;
            p_rs   <= lcd_rs;
            p_en   <= lcd_en;
            p_chg  <= w_chg;
            if (w_chg && lcd_en)
                stab_bad <= stab_bad + 1;
            else if (p_chg && !w_rise)
                stab_bad <= stab_bad + 1;
            en_len <= lcd_en ? en_len + 1 : 0;
            if (!lcd_en && p_en && en_len != 2)
                en_bad <= en_bad + 1;
            if (w_rise)
                caps.push_back('{lcd_data, lcd_rs, chr_msg, cyc});
            if (done) begin
                done_cyc.push_back(cyc);
                done_busy.push_back(busy);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_caps();
        caps.delete();
        done_cyc.delete();
        done_busy.delete();
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (done_cyc.size() < n)
            chk({name, "_timeout"}, done_cyc.size(), n);
    endtask

    task automatic check_page(input int base, input int m, input string name);
        int gap_bad = 0;
        if (caps.size() < base + PAGE_BYTES) begin
            chk({name, "_bytes"}, caps.size(), base + PAGE_BYTES);
            return;
        end
        for (int i = 0; i < PAGE_BYTES; i++) begin
            logic [7:0] ed;
            logic       ers;
            int         gap;
            if (i == 0) begin
                ed = 8'h80; ers = 1'b0;
            end else if (i == COLS + 1) begin
                ed = 8'hC0; ers = 1'b0;
            end else begin
                ers = 1'b1;
                ed  = rom_byte(m, (i <= COLS) ? i - 1 : i - 2);
            end
            chk($sformatf("%s_byte%0d", name, i),
                {21'b0, caps[base+i].m, caps[base+i].rs, caps[base+i].d},
                {21'b0, 2'(m), ers, ed});
            if (i > 0) begin
                gap = (i == COLS + 1) ? 7 : 9;
                if (caps[base+i].cyc - caps[base+i-1].cyc != gap)
                    gap_bad++;
            end
        end
        chk({name, "_gaps"}, gap_bad, 0);
    endtask

    task automatic count_pwrup(input string name);
        int k = 0;
        tick();
        chk({name, "_data_low"}, {24'b0, lcd_data}, 0);
        while (!lcd_en && k < 100) begin
            k++;
            tick();
        end
        chk({name, "_en_low_cycles"}, k, 10);
    endtask

    function automatic logic [31:0] out_val(input int i);
        case (i)
            0:       return {24'b0, lcd_data};
            1:       return {31'b0, lcd_en};
            2:       return {31'b0, lcd_rs};
            3:       return {31'b0, lcd_rw};
            4:       return {31'b0, busy};
            5:       return {31'b0, done};
            6:       return {30'b0, chr_msg};
            default: return {27'b0, chr_addr};
        endcase
    endfunction

    typedef struct {string name; logic [31:0] exp;} rst_vec_t;
    typedef struct {logic [7:0] d; logic rs; int gap;} init_vec_t;
    rst_vec_t  rst_tab[8];
    init_vec_t init_tab[5];

    initial begin
        int c;
        int k;
        rst_tab[0] = '{"rst_lcd_data", 0};
        rst_tab[1] = '{"rst_lcd_en", 0};
        rst_tab[2] = '{"rst_lcd_rs", 0};
        rst_tab[3] = '{"rst_lcd_rw", 0};
        rst_tab[4] = '{"rst_busy", 1};
        rst_tab[5] = '{"rst_done", 0};
        rst_tab[6] = '{"rst_chr_msg", 0};
        rst_tab[7] = '{"rst_chr_addr", 0};
        init_tab[0] = '{8'h38, 1'b0, 7};
        init_tab[1] = '{8'h0C, 1'b0, 7};
        init_tab[2] = '{8'h01, 1'b0, 11};
        init_tab[3] = '{8'h06, 1'b0, 7};
        init_tab[4] = '{8'h80, 1'b0, 9};

        rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8; i++)
            chk(rst_tab[i].name, out_val(i), rst_tab[i].exp);

        // Power-up, init and first page with message 0.
        clear_caps();
        rst_n = 1'b1;
        count_pwrup("pwrup");
        wait_dones(1, 2000, "init_done");
        repeat (5) tick();
        chk("init_done_count", done_cyc.size(), 1);
        chk("init_busy_low", {31'b0, busy}, 0);
        if (caps.size() >= 4 + PAGE_BYTES && done_cyc.size() >= 1) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("init_byte%0d", i), {23'b0, caps[i].rs, caps[i].d}, {23'b0, init_tab[i].rs, init_tab[i].d});
                chk($sformatf("init_gap%0d", i), caps[i+1].cyc - caps[i].cyc, init_tab[i].gap);
            end
            chk("init_done_busy", {31'b0, done_busy[0]}, 0);
            chk("done_after_last_byte", done_cyc[0] - caps[4 + PAGE_BYTES - 1].cyc, 6);
        end
        check_page(4, 0, "page0");

        // Message change 0 -> 2 while idle.
        clear_caps();
        msg_sel = 2'd2;
        c = cyc;
        tick();
        chk("busy_rise", {31'b0, busy}, 1);
        wait_dones(1, 1000, "msg2");
        if (done_cyc.size() >= 1)
            chk("page_len", done_cyc[0] - c, PAGE_CYC + 1);
        tick();
        chk("msg2_chr_msg", {30'b0, chr_msg}, 2);
        check_page(0, 2, "msg2");

        // Change 1 -> 3 during a write: finish page 1, then restart with 3.
        clear_caps();
        msg_sel = 2'd1;
        repeat (100) tick();
        msg_sel = 2'd3;
        wait_dones(2, 1500, "pend");
        repeat (3) tick();
        chk("pend_done_count", done_cyc.size(), 2);
        check_page(0, 1, "pend_first");
        check_page(PAGE_BYTES, 3, "pend_second");
        if (done_cyc.size() >= 2 && caps.size() > PAGE_BYTES) begin
            chk("pend_restart_busy", {31'b0, done_busy[0]}, 1);
            chk("pend_restart_gap", caps[PAGE_BYTES].cyc - done_cyc[0], 1);
        end
        chk("pend_chr_msg", {30'b0, chr_msg}, 3);

        // refresh_req and msg_sel change in the same cycle: exactly one write.
        clear_caps();
        msg_sel = 2'd0;
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
        wait_dones(1, 1000, "both");
        repeat (350) tick();
        chk("both_done_count", done_cyc.size(), 1);
        chk("both_byte_count", caps.size(), PAGE_BYTES);
        chk("both_chr_msg", {30'b0, chr_msg}, 0);

`ifdef LCD_AUTO_REFRESH_EN
        clear_caps();
        wait_dones(2, 2500, "auto");
        if (done_cyc.size() >= 2)
            chk("auto_period", done_cyc[1] - done_cyc[0], 500 + PAGE_CYC + 1);
        check_page(0, 0, "auto");
`else
        clear_caps();
        repeat (2000) tick();
        chk("idle_no_bytes", caps.size(), 0);
        chk("idle_no_done", done_cyc.size(), 0);
`endif

        // Reset in the middle of a write aborts and repeats power-up.
        repeat (5) tick();
        clear_caps();
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
        repeat (60) tick();
        k = 0;
        while (!lcd_en && k < 20) begin
            k++;
            tick();
        end
        chk("abort_en_before", {31'b0, lcd_en}, 1);
        rst_n = 1'b0;
        tick();
        chk("abort_en_low", {31'b0, lcd_en}, 0);
        chk("abort_busy", {31'b0, busy}, 1);
        chk("abort_data", {24'b0, lcd_data}, 0);
        tick();
        clear_caps();
        rst_n = 1'b1;
        count_pwrup("repwr");
        wait_dones(1, 2000, "repwr");
        tick();
        if (caps.size() >= 1)
            chk("repwr_first_byte", {23'b0, caps[0].rs, caps[0].d}, {23'b0, 1'b0, 8'h38});
        check_page(4, 0, "repwr");
        chk("repwr_done_count", done_cyc.size(), 1);

        chk("timing_en_width", en_bad, 0);
        chk("timing_data_stable", stab_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
